simon_sequencer: RTL and testbench

SIMON_SEQUENCER -- requirements
Module: simon_sequencer

---
 rtl/simon_pkg.sv | 34 +++
 rtl/rise_detect.sv | 25 ++
 rtl/simon_sequencer.sv | 146 ++++++++++++++
 tb/tb_simon_sequencer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// rtl/simon_pkg.sv - shared state encoding and speed constants for the Simon sequencer
package simon_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SEED,
        ST_ADD,
        ST_SPEED,
        ST_SHOW_ON,
        ST_SHOW_OFF,
        ST_PLAYER,
        ST_CHECK,
        ST_WIN,
        ST_LOSE
    } state_e;

    localparam logic [2:0] SPEED_0   = 3'd0;
    localparam logic [2:0] SPEED_1   = 3'd1;
    localparam logic [2:0] SPEED_2   = 3'd2;
    localparam logic [2:0] SPEED_3   = 3'd3;
    localparam logic [2:0] SPEED_4   = 3'd4;
    localparam logic [2:0] SPEED_MAX = SPEED_4;

    // done_rounds is the length before the round being added, i.e. (new_round - 1).
    function automatic logic [2:0] speed_code(input logic [5:0] done_rounds, input int rps);
        int step;
        step = int'(done_rounds) / rps;
        if (step >= int'(SPEED_MAX)) begin
            return SPEED_MAX;
        end
        return step[2:0];
    endfunction

endpackage

// File: rtl/rise_detect.sv
// rtl/rise_detect.sv - rising-edge detector for raw button levels
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic in_i,
    output logic edge_o
);

    logic prev_q;
    logic armed_q;

    // armed_q masks the first cycle after reset so a level held through reset is not an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            prev_q  <= in_i;
            armed_q <= 1'b1;
        end
    end

    assign edge_o = in_i & ~prev_q & armed_q;

endmodule

// File: rtl/simon_sequencer.sv
// rtl/simon_sequencer.sv - Moore game sequencer driving the Simon colour datapath
import simon_pkg::*;

module simon_sequencer #(
    parameter int MAX_ROUND        = 32,
    parameter int ROUNDS_PER_SPEED = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       go,
    input  logic       submit,
    input  logic       result,
    input  logic       empty,
    input  logic       pulse,
    output logic       start,
    output logic       rst_seedgen,
    output logic       load_colour,
    output logic       load_speed,
    output logic       flash_colour,
    output logic       player_turn,
    output logic [2:0] speed,
    output logic [4:0] check_round,
    output logic [5:0] round,
    output logic       win,
    output logic       lose
);

    localparam logic [5:0] MAX_ROUND_W = 6'(MAX_ROUND);

    state_e     state_q, state_d;
    logic [5:0] round_q, round_d;
    logic [4:0] check_q, check_d;
    logic [2:0] speed_q, speed_d;
    logic       seed_q, seed_d;
    logic       go_edge;
    logic       submit_edge;
    logic       last_index;

    rise_detect u_go_edge (
        .clk   (clk),
        .reset (reset),
        .in_i  (go),
        .edge_o(go_edge)
    );

    rise_detect u_submit_edge (
        .clk   (clk),
        .reset (reset),
        .in_i  (submit),
        .edge_o(submit_edge)
    );

    assign last_index = ({1'b0, check_q} == (round_q - 6'd1));

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        check_d = check_q;
        speed_d = speed_q;
        seed_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (go_edge) state_d = ST_SEED;
            end
            ST_SEED: state_d = ST_ADD;
            ST_ADD: begin
                // Speed is latched here so it is already valid while load_speed is high.
                round_d = round_q + 6'd1;
                speed_d = speed_code(round_q, ROUNDS_PER_SPEED);
                state_d = ST_SPEED;
            end
            ST_SPEED: begin
                check_d = '0;
                state_d = ST_SHOW_ON;
            end
            ST_SHOW_ON: begin
                if (pulse) state_d = ST_SHOW_OFF;
            end
            ST_SHOW_OFF: begin
                if (pulse) begin
                    if (last_index) begin
                        check_d = '0;
                        state_d = ST_PLAYER;
                    end else begin
                        check_d = check_q + 5'd1;
                        state_d = ST_SHOW_ON;
                    end
                end
            end
            ST_PLAYER: begin
                if (submit_edge) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (empty || !result) begin
                    state_d = ST_LOSE;
                end else if (!last_index) begin
                    check_d = check_q + 5'd1;
                    state_d = ST_PLAYER;
                end else if (round_q == MAX_ROUND_W) begin
                    state_d = ST_WIN;
                end else begin
                    state_d = ST_ADD;
                end
            end
            ST_WIN, ST_LOSE: begin
                if (go_edge) begin
                    state_d = ST_IDLE;
                    round_d = '0;
                    check_d = '0;
                    speed_d = SPEED_0;
                    seed_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            round_q <= '0;
            check_q <= '0;
            speed_q <= SPEED_0;
            seed_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            check_q <= check_d;
            speed_q <= speed_d;
            seed_q  <= seed_d;
        end
    end

    assign start        = (state_q == ST_SEED);
    assign rst_seedgen  = seed_q;
    assign load_colour  = (state_q == ST_ADD);
    assign load_speed   = (state_q == ST_SPEED);
    assign flash_colour = (state_q == ST_SHOW_ON);
    assign player_turn  = (state_q == ST_PLAYER);
    assign win          = (state_q == ST_WIN);
    assign lose         = (state_q == ST_LOSE);
    assign speed        = speed_q;
    assign check_round  = check_q;
    assign round        = round_q;

endmodule

// File: tb/tb_simon_sequencer.sv
// tb/tb_simon_sequencer.sv - directed self-checking bench for simon_sequencer
module tb_simon_sequencer;

    logic       clk = 1'b0;
    logic       reset, go, submit, result, empty, pulse;
    logic       start, rst_seedgen, load_colour, load_speed, flash_colour, player_turn, win, lose;
    logic [2:0] speed;
    logic [4:0] check_round;
    logic [5:0] round;
    logic       b_start, b_rst_seedgen, b_load_colour, b_load_speed, b_flash_colour, b_player_turn, b_win, b_lose;
    logic [2:0] b_speed;
    logic [4:0] b_check_round;
    logic [5:0] b_round;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    simon_sequencer #(.MAX_ROUND(5), .ROUNDS_PER_SPEED(1)) dut (
        .clk(clk), .reset(reset), .go(go), .submit(submit), .result(result), .empty(empty), .pulse(pulse),
        .start(start), .rst_seedgen(rst_seedgen), .load_colour(load_colour), .load_speed(load_speed),
        .flash_colour(flash_colour), .player_turn(player_turn), .speed(speed), .check_round(check_round),
        .round(round), .win(win), .lose(lose)
    );

    // Second instance: one round longer, exercises speed saturation past 4.
    simon_sequencer #(.MAX_ROUND(6), .ROUNDS_PER_SPEED(1)) dut6 (
        .clk(clk), .reset(reset), .go(go), .submit(submit), .result(result), .empty(empty), .pulse(pulse),
        .start(b_start), .rst_seedgen(b_rst_seedgen), .load_colour(b_load_colour), .load_speed(b_load_speed),
        .flash_colour(b_flash_colour), .player_turn(b_player_turn), .speed(b_speed), .check_round(b_check_round),
        .round(b_round), .win(b_win), .lose(b_lose)
    );

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            checks++;
            if ($countones({start, load_colour, load_speed, rst_seedgen}) > 1) begin
                failures++;
                $display("FAIL cmd_onehot got=%b exp=at most one", {start, load_colour, load_speed, rst_seedgen});
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; go = 1'b0; submit = 1'b0; result = 1'b0; empty = 1'b0; pulse = 1'b0;
        tick; tick;
        reset = 1'b0;
        checks++; if ({start, rst_seedgen, load_colour, load_speed, flash_colour, player_turn, win, lose} !== 8'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0", {start, rst_seedgen, load_colour, load_speed, flash_colour, player_turn, win, lose}); end
        checks++; if ({round, check_round, speed} !== 14'b0) begin failures++; $display("FAIL reset_counts got=%0d/%0d/%0d exp=0/0/0", round, check_round, speed); end
        reset = 1'b1; go = 1'b1;
        tick;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++; if (start !== 1'b0 || load_colour !== 1'b0) begin failures++; $display("FAIL go_held_reset got=%b%b exp=00", start, load_colour); end
        end
        go = 1'b0;
        tick;
    endtask

    task automatic start_game;
        go = 1'b1; tick; go = 1'b0;
        checks++; if (start !== 1'b1) begin failures++; $display("FAIL seed_start got=%b exp=1", start); end
        tick;
        checks++; if (load_colour !== 1'b1 || start !== 1'b0 || round !== 6'd0) begin failures++; $display("FAIL add_first got=%b/%0d exp=1/0", load_colour, round); end
        tick;
        checks++; if (load_speed !== 1'b1 || speed !== 3'd0 || round !== 6'd1) begin failures++; $display("FAIL speed_first got=%b/%0d/%0d exp=1/0/1", load_speed, speed, round); end
        tick;
        checks++; if (flash_colour !== 1'b1 || check_round !== 5'd0) begin failures++; $display("FAIL first_flash got=%b/%0d exp=1/0", flash_colour, check_round); end
    endtask

    task automatic show_round(input int r);
        for (int i = 0; i < r; i++) begin
            checks++; if (flash_colour !== 1'b1 || check_round !== 5'(i)) begin failures++; $display("FAIL show_on got=%b/%0d exp=1/%0d", flash_colour, check_round, i); end
            repeat (4) tick;
            pulse = 1'b1; tick; pulse = 1'b0;
            checks++; if (flash_colour !== 1'b0 || player_turn !== 1'b0 || check_round !== 5'(i)) begin failures++; $display("FAIL show_off got=%b%b/%0d exp=00/%0d", flash_colour, player_turn, check_round, i); end
            repeat (4) tick;
            pulse = 1'b1; tick; pulse = 1'b0;
        end
        checks++; if (player_turn !== 1'b1 || flash_colour !== 1'b0 || check_round !== 5'd0) begin failures++; $display("FAIL show_done got=%b%b/%0d exp=10/0", player_turn, flash_colour, check_round); end
        pulse = 1'b1; tick; pulse = 1'b0;
        checks++; if (player_turn !== 1'b1) begin failures++; $display("FAIL player_pulse got=%b exp=1", player_turn); end
    endtask

    task automatic answer_all(input int r);
        for (int i = 0; i < r; i++) begin
            checks++; if (player_turn !== 1'b1 || check_round !== 5'(i)) begin failures++; $display("FAIL player_idx got=%b/%0d exp=1/%0d", player_turn, check_round, i); end
            submit = 1'b1; result = 1'b1; tick; submit = 1'b0;
            checks++; if (player_turn !== 1'b0) begin failures++; $display("FAIL check_cycle got=%b exp=0", player_turn); end
            tick; result = 1'b0;
        end
    endtask

    task automatic next_round(input int r_new, input logic [2:0] sp);
        checks++; if (load_colour !== 1'b1) begin failures++; $display("FAIL add_next got=%b exp=1", load_colour); end
        tick;
        checks++; if (load_speed !== 1'b1 || speed !== sp || round !== 6'(r_new)) begin failures++; $display("FAIL speed_next got=%b/%0d/%0d exp=1/%0d/%0d", load_speed, speed, round, sp, r_new); end
        tick;
        checks++; if (flash_colour !== 1'b1) begin failures++; $display("FAIL show_next got=%b exp=1", flash_colour); end
    endtask

    task automatic test_game_win;
        start_game;
        show_round(1); answer_all(1); next_round(2, 3'd1);
        show_round(2); answer_all(2); next_round(3, 3'd2);
        submit = 1'b1; tick; submit = 1'b0;
        checks++; if (flash_colour !== 1'b1 || player_turn !== 1'b0 || check_round !== 5'd0) begin failures++; $display("FAIL submit_in_show got=%b%b/%0d exp=10/0", flash_colour, player_turn, check_round); end
        show_round(3); answer_all(3); next_round(4, 3'd3);
        show_round(4); answer_all(4); next_round(5, 3'd4);
        show_round(5); answer_all(5);
        checks++; if (win !== 1'b1 || load_colour !== 1'b0 || round !== 6'd5 || check_round !== 5'd4) begin failures++; $display("FAIL win got=%b%b/%0d/%0d exp=10/5/4", win, load_colour, round, check_round); end
        checks++; if (b_load_colour !== 1'b1 || b_win !== 1'b0) begin failures++; $display("FAIL max6_add got=%b%b exp=10", b_load_colour, b_win); end
        tick;
        checks++; if (b_load_speed !== 1'b1 || b_speed !== 3'd4 || b_round !== 6'd6) begin failures++; $display("FAIL speed_sat got=%b/%0d/%0d exp=1/4/6", b_load_speed, b_speed, b_round); end
        checks++; if (win !== 1'b1 || load_colour !== 1'b0 || round !== 6'd5) begin failures++; $display("FAIL win_hold got=%b%b/%0d exp=10/5", win, load_colour, round); end
        go = 1'b1; tick;
        checks++; if (rst_seedgen !== 1'b1 || win !== 1'b0 || round !== 6'd0 || start !== 1'b0) begin failures++; $display("FAIL win_restart got=%b%b/%0d exp=10/0", rst_seedgen, win, round); end
        tick;
        checks++; if (rst_seedgen !== 1'b0 || start !== 1'b0) begin failures++; $display("FAIL seedgen_once got=%b%b exp=00", rst_seedgen, start); end
        go = 1'b0; tick;
    endtask

    task automatic test_lose_and_hold_go;
        start_game;
        show_round(1); answer_all(1); next_round(2, 3'd1);
        show_round(2); answer_all(2); next_round(3, 3'd2);
        show_round(3);
        submit = 1'b1; result = 1'b1; tick; submit = 1'b0; tick;
        checks++; if (player_turn !== 1'b1 || check_round !== 5'd1) begin failures++; $display("FAIL lose_second got=%b/%0d exp=1/1", player_turn, check_round); end
        result = 1'b0; submit = 1'b1; tick; submit = 1'b0; tick;
        checks++; if (lose !== 1'b1 || round !== 6'd3 || check_round !== 5'd1 || player_turn !== 1'b0) begin failures++; $display("FAIL lose got=%b/%0d/%0d exp=1/3/1", lose, round, check_round); end
        go = 1'b1; tick;
        checks++; if (rst_seedgen !== 1'b1 || lose !== 1'b0 || round !== 6'd0) begin failures++; $display("FAIL lose_restart got=%b%b/%0d exp=10/0", rst_seedgen, lose, round); end
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++; if (start !== 1'b0 || rst_seedgen !== 1'b0) begin failures++; $display("FAIL go_held_idle got=%b%b exp=00", start, rst_seedgen); end
        end
        go = 1'b0; tick;
    endtask

    task automatic test_empty;
        start_game;
        show_round(1);
        submit = 1'b1; result = 1'b1; empty = 1'b1; tick; submit = 1'b0; tick;
        checks++; if (lose !== 1'b1 || win !== 1'b0 || load_colour !== 1'b0) begin failures++; $display("FAIL empty_lose got=%b%b%b exp=100", lose, win, load_colour); end
        empty = 1'b0; result = 1'b0;
        go = 1'b1; tick; go = 1'b0; tick;
    endtask

    task automatic test_reset_mid;
        start_game;
        reset = 1'b1; tick; reset = 1'b0;
        checks++; if ({start, rst_seedgen, load_colour, load_speed, flash_colour, player_turn, win, lose} !== 8'b0 || round !== 6'd0) begin failures++; $display("FAIL reset_show got=%b/%0d exp=0/0", {start, rst_seedgen, load_colour, load_speed, flash_colour, player_turn, win, lose}, round); end
        tick;
        start_game;
        show_round(1);
        reset = 1'b1; tick; reset = 1'b0;
        checks++; if ({start, rst_seedgen, load_colour, load_speed, flash_colour, player_turn, win, lose} !== 8'b0) begin failures++; $display("FAIL reset_player got=%b exp=0", {start, rst_seedgen, load_colour, load_speed, flash_colour, player_turn, win, lose}); end
        checks++; if ({round, check_round, speed} !== 14'b0) begin failures++; $display("FAIL reset_player_counts got=%0d/%0d/%0d exp=0/0/0", round, check_round, speed); end
    endtask

    initial begin
        #2000000;
        failures++;
        $display("FAIL timeout got=running exp=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        test_reset;
        test_game_win;
        test_lose_and_hold_go;
        test_empty;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
